// File: rtl/parking_meter_multi_if.sv
// Command and display bundle between the button front end, the meter core and the scan driver.
interface parking_meter_multi_if #(
  parameter int unsigned SPACES = 4,
  parameter int unsigned SEL_W  = 2
);
  logic [SEL_W-1:0]  sel;
  logic              coin_valid;
  logic [1:0]        coin_type;
  logic              preset_valid;
  logic [13:0]       preset_val;
  logic              clear_valid;
  logic [13:0]       time_sec;
  logic [15:0]       time_bcd;
  logic [SPACES-1:0] expired;
  logic [SPACES-1:0] low;
  logic              blank;
  logic              sec_tick;

  // Command source / display consumer side
  modport master (
    output sel, coin_valid, coin_type, preset_valid, preset_val, clear_valid,
    input  time_sec, time_bcd, expired, low, blank, sec_tick
  );

  // Meter core side
  modport slave (
    input  sel, coin_valid, coin_type, preset_valid, preset_val, clear_valid,
    output time_sec, time_bcd, expired, low, blank, sec_tick
  );
endinterface

// File: rtl/parking_meter_multi.sv
// Multi-space parking meter core: per-space seconds countdown with coin/preset/clear
// commands, saturating arithmetic, and registered binary/BCD/blink outputs for the
// selected space.
module parking_meter_multi #(
  parameter int unsigned SPACES   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MAX_SEC  = 9999,
  parameter int unsigned LOW_SEC  = 180,
  parameter int unsigned COIN0    = 60,
  parameter int unsigned COIN1    = 120,
  parameter int unsigned COIN2    = 180,
  parameter int unsigned COIN3    = 300
) (
  input logic                  clk,
  input logic                  rst,
  parking_meter_multi_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PrescHalf = PW'(TICK_DIV / 2);
  localparam logic [13:0]   MaxSec    = 14'(MAX_SEC);
  localparam logic [13:0]   LowSec    = 14'(LOW_SEC);

  // Exact double-dabble conversion; valid for 0..9999.
  function automatic logic [15:0] bin2bcd(input logic [13:0] b);
    logic [29:0] s;
    s = {16'd0, b};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (s[14+4*d +: 4] >= 4'd5) s[14+4*d +: 4] = s[14+4*d +: 4] + 4'd3;
      end
      s = s << 1;
    end
    return s[29:14];
  endfunction

  logic [PW-1:0]     presc_q;
  logic              odd_q;
  logic              tick;
  logic              tick_q;
  logic [13:0]       cnt_q    [SPACES];
  logic [13:0]       cnt_d    [SPACES];
  logic [13:0]       dec      [SPACES];
  logic [14:0]       coin_sum [SPACES];
  logic [13:0]       coin_amt;
  logic [13:0]       preset_sat;
  logic [13:0]       sel_val;
  logic              sel_ok;
  logic [SPACES-1:0] expired_d;
  logic [SPACES-1:0] low_d;
  logic              blank_d;

  logic [13:0]       time_sec_q;
  logic [15:0]       time_bcd_q;
  logic [SPACES-1:0] expired_q;
  logic [SPACES-1:0] low_q;
  logic              blank_q;
  logic              sec_tick_q;

  assign tick = (presc_q == PrescLast);

  // Coin denomination lookup and preset clamp
  always_comb begin
    coin_amt = 14'(COIN0);
    unique case (bus.coin_type)
      2'd0: coin_amt = 14'(COIN0);
      2'd1: coin_amt = 14'(COIN1);
      2'd2: coin_amt = 14'(COIN2);
      2'd3: coin_amt = 14'(COIN3);
    endcase
    preset_sat = (bus.preset_val > MaxSec) ? MaxSec : bus.preset_val;
  end

  // Per-space next value: tick decrement first, then the highest-priority command
  always_comb begin
    for (int i = 0; i < SPACES; i++) begin
      dec[i]      = (tick && cnt_q[i] != 14'd0) ? cnt_q[i] - 14'd1 : cnt_q[i];
      coin_sum[i] = {1'b0, dec[i]} + {1'b0, coin_amt};
      cnt_d[i]    = dec[i];
      // Out-of-range sel never matches any space, so such commands are dropped.
      if (bus.sel == SEL_W'(i)) begin
        if (bus.clear_valid) begin
          cnt_d[i] = 14'd0;
        end else if (bus.preset_valid) begin
          cnt_d[i] = preset_sat;
        end else if (bus.coin_valid) begin
          cnt_d[i] = (coin_sum[i] > {1'b0, MaxSec}) ? MaxSec : coin_sum[i][13:0];
        end
      end
    end
  end

  // Selected-space value and status flags derived from the current counters
  always_comb begin
    sel_val = 14'd0;
    sel_ok  = 1'b0;
    for (int i = 0; i < SPACES; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_val = cnt_q[i];
        sel_ok  = 1'b1;
      end
      expired_d[i] = (cnt_q[i] == 14'd0);
      low_d[i]     = (cnt_q[i] != 14'd0) && (cnt_q[i] < LowSec);
    end
    if (!sel_ok) begin
      blank_d = 1'b1;
    end else if (sel_val == 14'd0) begin
      blank_d = odd_q;
    end else if (sel_val < LowSec) begin
      blank_d = (presc_q >= PrescHalf);
    end else begin
      blank_d = 1'b0;
    end
  end

  // Prescaler, blink parity and space counters
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      odd_q   <= 1'b0;
      tick_q  <= 1'b0;
      for (int i = 0; i < SPACES; i++) cnt_q[i] <= 14'd0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      odd_q   <= odd_q ^ tick;
      tick_q  <= tick;
      for (int i = 0; i < SPACES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Registered outputs, one edge behind the counters; sec_tick is delayed to match
  always_ff @(posedge clk) begin
    if (rst) begin
      time_sec_q <= 14'd0;
      time_bcd_q <= 16'h0000;
      expired_q  <= '1;
      low_q      <= '0;
      blank_q    <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      time_sec_q <= sel_val;
      time_bcd_q <= bin2bcd(sel_val);
      expired_q  <= expired_d;
      low_q      <= low_d;
      blank_q    <= blank_d;
      sec_tick_q <= tick_q;
    end
  end

  assign bus.time_sec = time_sec_q;
  assign bus.time_bcd = time_bcd_q;
  assign bus.expired  = expired_q;
  assign bus.low      = low_q;
  assign bus.blank    = blank_q;
  assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_parking_meter_multi.sv
// Bench for parking_meter_multi with 3 spaces and a 10-cycle second: directed scenarios
// followed by random commands, all checked against a cycle-level reference model.
module tb_parking_meter_multi;

  localparam int NSP = 3;
  localparam int TD  = 10;
  localparam int MAXS = 9999;
  localparam int LOWS = 180;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  parking_meter_multi_if #(.SPACES(NSP), .SEL_W(2)) bus ();

  parking_meter_multi #(
    .SPACES  (NSP),
    .SEL_W   (2),
    .TICK_DIV(TD)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_cnt [NSP];
  int m_presc;
  bit m_odd;
  bit m_last_tick;
  int coins [4] = '{60, 120, 180, 300};

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.coin_valid   = 1'b0;
    bus.preset_valid = 1'b0;
    bus.clear_valid  = 1'b0;
  endtask

  // One clock: predict outputs after the edge, advance the model, then compare
  task automatic cycle();
    int  e_time, e_bcd, e_exp, e_low, t, s, v;
    bit  e_blank, e_tick, tick, ok;
    s = int'(bus.sel);
    if (rst) begin
      e_time = 0; e_bcd = 0; e_exp = (1 << NSP) - 1; e_low = 0; e_blank = 0; e_tick = 0;
      for (int i = 0; i < NSP; i++) m_cnt[i] = 0;
      m_presc = 0; m_odd = 0; m_last_tick = 0;
    end else begin
      ok = (s < NSP);
      t  = ok ? m_cnt[s] : 0;
      e_time = t;
      e_bcd  = to_bcd(t);
      e_exp = 0; e_low = 0;
      for (int i = 0; i < NSP; i++) begin
        if (m_cnt[i] == 0) e_exp |= (1 << i);
        if (m_cnt[i] > 0 && m_cnt[i] < LOWS) e_low |= (1 << i);
      end
      if (!ok) e_blank = 1;
      else if (t == 0) e_blank = m_odd;
      else if (t < LOWS) e_blank = (m_presc >= TD / 2);
      else e_blank = 0;
      e_tick = m_last_tick;
      tick = (m_presc == TD - 1);
      for (int i = 0; i < NSP; i++) begin
        v = m_cnt[i];
        if (tick && v > 0) v = v - 1;
        if (i == s) begin
          if (bus.clear_valid) v = 0;
          else if (bus.preset_valid) v = (int'(bus.preset_val) > MAXS) ? MAXS : int'(bus.preset_val);
          else if (bus.coin_valid) v = (v + coins[bus.coin_type] > MAXS) ? MAXS
                                                                         : v + coins[bus.coin_type];
        end
        m_cnt[i] = v;
      end
      m_presc = (m_presc + 1) % TD;
      if (tick) m_odd = !m_odd;
      m_last_tick = tick;
    end
    @(posedge clk);
    #1;
    chk("time_sec", 32'(bus.time_sec), 32'(e_time));
    chk("time_bcd", 32'(bus.time_bcd), 32'(e_bcd));
    chk("expired",  32'(bus.expired),  32'(e_exp));
    chk("low",      32'(bus.low),      32'(e_low));
    chk("blank",    32'(bus.blank),    32'(e_blank));
    chk("sec_tick", 32'(bus.sec_tick), 32'(e_tick));
  endtask

  task automatic align_tick();
    // Idle until the next edge carries a tick (at most one second)
    for (int k = 0; k < TD && m_presc != TD - 1; k++) cycle();
  endtask

  int pulses;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.sel = 2'd0;
    bus.coin_type = 2'd0;
    bus.preset_val = 14'd0;
    idle_inputs();
    cycle();
    cycle();
    chk("reset_expired", 32'(bus.expired), 32'h7);
    rst = 1'b0;

    // Coin type 3 on space 0, then one second of countdown
    bus.sel = 2'd0;
    bus.coin_valid = 1'b1; bus.coin_type = 2'd3;
    cycle();
    idle_inputs();
    cycle();
    chk("coin300_sec", 32'(bus.time_sec), 32'd300);
    chk("coin300_bcd", 32'(bus.time_bcd), 32'h0300);
    pulses = 0;
    for (int k = 0; k < TD; k++) begin
      cycle();
      if (bus.sec_tick) pulses++;
    end
    chk("after_1s_sec", 32'(bus.time_sec), 32'd299);
    chk("tick_pulses", 32'(pulses), 32'd1);

    // Saturation on space 1
    bus.sel = 2'd1;
    bus.preset_valid = 1'b1; bus.preset_val = 14'd9990;
    cycle();
    idle_inputs();
    bus.coin_valid = 1'b1; bus.coin_type = 2'd0;
    cycle();
    idle_inputs();
    cycle();
    chk("coin_sat", 32'(bus.time_sec), 32'd9999);
    bus.preset_valid = 1'b1; bus.preset_val = 14'd12000;
    cycle();
    idle_inputs();
    cycle();
    chk("preset_sat", 32'(bus.time_sec), 32'd9999);

    // Space 2 runs out and blinks with the parity bit
    bus.sel = 2'd2;
    bus.preset_valid = 1'b1; bus.preset_val = 14'd2;
    cycle();
    idle_inputs();
    cycle();
    for (int k = 0; k < 4 * TD && !bus.expired[2]; k++) cycle();
    chk("space2_expired", 32'(bus.expired[2]), 32'd1);
    chk("space2_zero", 32'(bus.time_sec), 32'd0);
    for (int k = 0; k < 3 * TD; k++) cycle();

    // Low-time blink on space 0
    bus.sel = 2'd0;
    bus.preset_valid = 1'b1; bus.preset_val = 14'd100;
    cycle();
    idle_inputs();
    cycle();
    chk("low0", 32'(bus.low[0]), 32'd1);
    for (int k = 0; k < 2 * TD; k++) cycle();

    // Tick coincident with a coin on a space holding 5
    bus.sel = 2'd1;
    bus.preset_valid = 1'b1; bus.preset_val = 14'd5;
    cycle();
    idle_inputs();
    align_tick();
    bus.coin_valid = 1'b1; bus.coin_type = 2'd1;
    cycle();
    idle_inputs();
    cycle();
    chk("tick_coin", 32'(bus.time_sec), 32'd124);

    // Tick coincident with clear+preset+coin: clear wins
    align_tick();
    bus.clear_valid = 1'b1; bus.preset_valid = 1'b1; bus.preset_val = 14'd500;
    bus.coin_valid = 1'b1; bus.coin_type = 2'd3;
    cycle();
    idle_inputs();
    cycle();
    chk("tick_clear", 32'(bus.time_sec), 32'd0);

    // Out-of-range select
    bus.sel = 2'd3;
    bus.coin_valid = 1'b1; bus.coin_type = 2'd3;
    cycle();
    idle_inputs();
    cycle();
    chk("sel3_time", 32'(bus.time_sec), 32'd0);
    chk("sel3_blank", 32'(bus.blank), 32'd1);

    // Reset with live counters, with a command presented during reset
    bus.sel = 2'd0;
    bus.preset_valid = 1'b1; bus.preset_val = 14'd50;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle_inputs();
    cycle();
    chk("rst_expired", 32'(bus.expired), 32'h7);
    chk("rst_time", 32'(bus.time_sec), 32'd0);

    // Random commands
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.sel = 2'($urandom_range(0, 3));
      bus.coin_valid = ($urandom_range(0, 3) == 0);
      bus.coin_type = 2'($urandom_range(0, 3));
      bus.preset_valid = ($urandom_range(0, 9) == 0);
      bus.preset_val = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                                   : 14'($urandom_range(0, 250));
      bus.clear_valid = ($urandom_range(0, 19) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_meter_multi.md
# parking_meter_multi

Multi-space, parameterised parking meter core: it keeps an independent seconds countdown per space, with coin add, preset and clear commands, and saturating arithmetic. For the selected space it presents the remaining time in binary and BCD, plus a blink-gating signal. It sits between the debounced button/switch front end and the 7-segment scan driver, replacing the single-space meter datapath.

## Interface
- SPACES, 4: number of independent meters (1..16).
- SEL_W, 2: width of `sel`; must satisfy 2^SEL_W >= SPACES.
- TICK_DIV, 100_000_000: clk cycles per second (>= 4, even).
- MAX_SEC, 9999: saturation ceiling (<= 9999).
- LOW_SEC, 180: low-time threshold.
- COIN0 / COIN1 / COIN2 / COIN3, 60 / 120 / 180 / 300: seconds added per coin type.

Ports (clock and reset first):
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  SEL_W  space targeted by commands and shown on the outputs.
- coin_valid  in  1  add COIN[coin_type] to space `sel`.
- coin_type  in  2  coin selector.
- preset_valid  in  1  load `preset_val` into space `sel`.
- preset_val  in  14  preset seconds.
- clear_valid  in  1  force space `sel` to 0.
- time_sec  out  14  remaining seconds of the selected space.
- time_bcd  out  16  the same value as four BCD digits, thousands digit in [15:12].
- expired  out  SPACES  bit i = space i at 0.
- low  out  SPACES  bit i = 0 < space i < LOW_SEC.
- blank  out  1  display gating for the selected space (1 = digits off).
- sec_tick  out  1  one-cycle pulse per second.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. The internal tick fires in the cycle the count equals TICK_DIV-1. A parity bit `odd` toggles on every tick.
- On a tick, every nonzero space decrements by 1. Spaces at 0 stay at 0 (no wrap).
- Only one command executes per cycle, on space `sel`. Priority: clear > preset > coin. Lower-priority valids in the same cycle are dropped.
- If `sel` >= SPACES, commands are ignored, time_sec/time_bcd = 0 and blank = 1.
- Coin: new = min(MAX_SEC, t' + COIN[coin_type]), where t' is the value after this cycle's tick decrement (decrement first, then add, then saturate).
- Preset: new = min(preset_val, MAX_SEC). A tick in the same cycle does not decrement the preset space.
- Clear: new = 0, regardless of tick.
- Spaces not addressed by a command still decrement on a tick in the same cycle.
- Blank rule for the selected value t:
  - t == 0: blank = `odd` (0.5 Hz, 50% duty).
  - 0 < t < LOW_SEC: blank = 1 while prescaler >= TICK_DIV/2 (1 Hz, 50% duty).
  - Otherwise: blank = 0.
- BCD conversion is exact for 0..9999. Binary-to-BCD logic may be combinational or iterative, but must meet the latency below.

## Timing
- Reset (rst high at an edge):
  - All space counters, prescaler and `odd` clear to 0.
  - Outputs take their reset values: time_sec = 0, time_bcd = 0x0000, expired = all ones, low = 0, blank = 0, sec_tick = 0.
- Reset mid-countdown or mid-command discards all state. Commands presented while rst is high are ignored.
- Space counters update on the edge that samples a command or tick (edge k).
- All outputs are registered and reflect the counters one cycle later (edge k+1). Command-to-display latency is therefore 2 edges from presentation.
- sec_tick is high in the cycle after the decrement edge, aligned with the updated outputs.
- Changing `sel` updates time_sec, time_bcd and blank one cycle later. expired and low do not depend on `sel`.
- Commands are level-sampled every cycle. Upstream guarantees single-cycle valid pulses; a held valid repeats the command every cycle.

## Test plan
Benches run with TICK_DIV=10.
- Reset, then sel=0, coin_type=3 pulse → time_sec=300 and time_bcd=0x0300 two edges later. After 10 more cycles → 299, with sec_tick pulsing once.
- Preset space 1 to 9990, then coin_type=0 → 9999 (saturated). preset_val=12000 → 9999.
- Space 2 preset to 2 → decrements to 1, then 0, then stays 0. expired[2] rises with the 0. blank follows `odd` (toggles every 10 cycles).
- Space 0 preset to 100 → low[0]=1. blank is 0 for prescaler 0..4 and 1 for 5..9, every second.
- In one cycle, tick coincides with coin_type=1 on a space at 5 → 124. Tick coincides with clear+preset+coin on one space → 0. Other spaces still decrement.
- With SPACES=3, sel=3: coin ignored, time_sec=0, blank=1. Assert rst while space counters are nonzero → all cleared, expired=3'b111.
